// File: rtl/aes_pkg.sv
// Shared types and constants for the AES command sequencer.
package aes_pkg;

    localparam int AES_W = 128;

    typedef enum logic [2:0] {
        IDLE,
        KEYLD,
        START,
        WAIT,
        RESULT
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_NOKEY   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level, plus a one-cycle
// pulse on its synchronised rising edge. Also used on the LDO chip-select path.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the async level through the chain and remember the last synced value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/aes_cmd_sequencer.sv
// Accepts SPI-assembled commands, drives key loads and block operations on
// the AES core with a watchdog, and holds the result for SPI readback.
module aes_cmd_sequencer
    import aes_pkg::*;
#(
    parameter int DATA_W      = AES_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_encrypt,
    input  logic              cmd_is_key,
    output logic              aes_key_load,
    output logic [DATA_W-1:0] aes_key,
    output logic              aes_start,
    output logic [DATA_W-1:0] aes_din,
    output logic              aes_encrypt,
    input  logic              aes_done,
    input  logic [DATA_W-1:0] aes_dout,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_encrypt,
    output logic              busy,
    output logic              key_loaded,
    output logic [1:0]        err
);

    // One spare bit so the count never wraps while waiting.
    localparam int             CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             cmd_evt;
    logic [CNT_W-1:0] cnt_q;
    logic             done_hit;
    logic             timeout_hit;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (cmd_valid),
        .rise     (cmd_evt)
    );

    // A done coinciding with the terminal count takes priority over the abort.
    assign done_hit    = (state_q == WAIT) && aes_done;
    assign timeout_hit = (state_q == WAIT) && !aes_done && (cnt_q == CNT_LAST);
    assign busy        = (state_q != IDLE);

    // Next-state decode; the key-load strobe is a Moore output of KEYLD.
    always_comb begin
        state_d      = state_q;
        aes_key_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_evt) begin
                    if (cmd_is_key)      state_d = KEYLD;
                    else if (key_loaded) state_d = START;
                end
            end
            KEYLD: begin
                aes_key_load = 1'b1;
                state_d      = IDLE;
            end
            START:  state_d = WAIT;
            WAIT: begin
                if (done_hit)         state_d = RESULT;
                else if (timeout_hit) state_d = IDLE;
            end
            RESULT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Datapath: command capture, start strobe, watchdog, result hold and status.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            aes_key     <= '0;
            aes_din     <= '0;
            aes_encrypt <= 1'b0;
            aes_start   <= 1'b0;
            cnt_q       <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_encrypt <= 1'b0;
            key_loaded  <= 1'b0;
            err         <= ERR_NONE;
        end else begin
            // Registered strobe: lands two cycles after the accepting cmd_evt.
            aes_start <= (state_q == START);

            if (state_q == START)     cnt_q <= '0;
            else if (state_q == WAIT) cnt_q <= cnt_q + 1'b1;

            if (state_q == KEYLD) key_loaded <= 1'b1;

            if (done_hit) begin
                res_data    <= aes_dout;
                res_encrypt <= aes_encrypt;
                res_valid   <= 1'b1;
            end

            if (timeout_hit) err <= ERR_TIMEOUT;

            if (cmd_evt) begin
                if (state_q == IDLE) begin
                    err <= ERR_NONE;
                    if (cmd_is_key) begin
                        aes_key <= cmd_data;
                    end else if (key_loaded) begin
                        aes_din     <= cmd_data;
                        aes_encrypt <= cmd_encrypt;
                        res_valid   <= 1'b0;
                    end else begin
                        err <= ERR_NOKEY;
                    end
                end else begin
                    // Busy: drop the command, leave the running op alone.
                    err <= ERR_OVERRUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_cmd_sequencer.sv
// Directed bench for aes_cmd_sequencer: vector table plus corner-case sequences.
module tb_aes_cmd_sequencer;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [127:0] cmd_data = '0;
    logic         cmd_encrypt = 1'b0;
    logic         cmd_is_key = 1'b0;
    logic         aes_key_load, aes_start, aes_encrypt;
    logic [127:0] aes_key, aes_din;
    logic         aes_done;
    logic [127:0] aes_dout;
    logic         res_valid, res_encrypt, busy, key_loaded;
    logic [127:0] res_data;
    logic [1:0]   err;

    aes_cmd_sequencer #(.DATA_W(128), .SYNC_STAGES(2), .TIMEOUT(64)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .cmd_encrypt  (cmd_encrypt),
        .cmd_is_key   (cmd_is_key),
        .aes_key_load (aes_key_load),
        .aes_key      (aes_key),
        .aes_start    (aes_start),
        .aes_din      (aes_din),
        .aes_encrypt  (aes_encrypt),
        .aes_done     (aes_done),
        .aes_dout     (aes_dout),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_encrypt  (res_encrypt),
        .busy         (busy),
        .key_loaded   (key_loaded),
        .err          (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int   n_start = 0, n_load = 0, n_busy = 0;
    int   start_cyc = 0, load_cyc = 0, done_cyc = 0, rv_cyc = 0, errt_cyc = 0;
    logic rv_prev = 1'b0;
    logic [1:0] err_prev = 2'd0;
    always @(negedge clk) begin
        if (aes_start)    begin n_start <= n_start + 1; start_cyc <= cyc; end
        if (aes_key_load) begin n_load <= n_load + 1; load_cyc <= cyc; end
        if (aes_done)     done_cyc <= cyc;
        if (res_valid && !rv_prev) rv_cyc <= cyc;
        rv_prev <= res_valid;
        if (busy) n_busy <= n_busy + 1;
        if (err == 2'd2 && err_prev != 2'd2) errt_cyc <= cyc;
        err_prev <= err;
    end

    // Core model: answers each aes_start with core_resp after core_lat cycles.
    logic         core_en = 1'b1;
    int           core_lat = 10;
    logic [127:0] core_resp = '0;
    initial begin
        aes_done = 1'b0;
        aes_dout = '0;
        forever begin
            @(negedge clk);
            if (aes_start && core_en) begin
                repeat (core_lat) @(posedge clk);
                #1;
                aes_done = 1'b1;
                aes_dout = core_resp;
                @(posedge clk);
                #1;
                aes_done = 1'b0;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int drive_cyc = 0;

    task automatic send(input logic is_key, input logic enc, input logic [127:0] data);
        @(posedge clk);
        #1;
        cmd_is_key  = is_key;
        cmd_encrypt = enc;
        cmd_data    = data;
        cmd_valid   = 1'b1;
        drive_cyc   = cyc;
    endtask

    task automatic drop();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    typedef struct {
        logic         is_key;
        logic         enc;
        logic [127:0] data;
        logic [127:0] resp;
        logic         exp_kl;
        logic [1:0]   exp_err;
        logic         exp_rv;
        logic [127:0] exp_rd;
        logic         exp_re;
        int           exp_starts;
        int           exp_loads;
    } vec_t;

    function automatic vec_t mk(logic is_key, logic enc, logic [127:0] data, logic [127:0] resp,
                                logic kl, logic [1:0] e, logic rv, logic [127:0] rd, logic re,
                                int st, int ld);
        vec_t v;
        v.is_key = is_key; v.enc = enc; v.data = data; v.resp = resp;
        v.exp_kl = kl; v.exp_err = e; v.exp_rv = rv; v.exp_rd = rd; v.exp_re = re;
        v.exp_starts = st; v.exp_loads = ld;
        return v;
    endfunction

    vec_t vecs[6];

    initial begin
        int s0, l0, b0;

        vecs[0] = mk(1'b0, 1'b1, P1, C1, 1'b0, 2'd1, 1'b0, '0, 1'b0, 0, 0); // data, no key
        vecs[1] = mk(1'b1, 1'b0, K1, '0, 1'b1, 2'd0, 1'b0, '0, 1'b0, 0, 1); // key load
        vecs[2] = mk(1'b0, 1'b1, P1, C1, 1'b1, 2'd0, 1'b1, C1, 1'b1, 1, 0); // encrypt
        vecs[3] = mk(1'b0, 1'b0, C1, P1, 1'b1, 2'd0, 1'b1, P1, 1'b0, 1, 0); // decrypt
        vecs[4] = mk(1'b1, 1'b0, K2, '0, 1'b1, 2'd0, 1'b1, P1, 1'b0, 0, 1); // rekey keeps result
        vecs[5] = mk(1'b0, 1'b1, P2, C2, 1'b1, 2'd0, 1'b1, C2, 1'b1, 1, 0); // encrypt again

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        chk("rst_key_loaded", 128'(key_loaded), 128'd0);
        chk("rst_res_valid", 128'(res_valid), 128'd0);
        chk("rst_start", 128'(aes_start), 128'd0);
        chk("rst_key_load", 128'(aes_key_load), 128'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // Table-driven commands
        for (int i = 0; i < 6; i++) begin
            core_resp = vecs[i].resp;
            s0 = n_start; l0 = n_load; b0 = n_busy;
            send(vecs[i].is_key, vecs[i].enc, vecs[i].data);
            repeat (30) @(posedge clk);
            drop();
            repeat (4) @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_err", i), 128'(err), 128'(vecs[i].exp_err));
            chk($sformatf("v%0d_key_loaded", i), 128'(key_loaded), 128'(vecs[i].exp_kl));
            chk($sformatf("v%0d_res_valid", i), 128'(res_valid), 128'(vecs[i].exp_rv));
            chk($sformatf("v%0d_res_data", i), res_data, vecs[i].exp_rd);
            chk($sformatf("v%0d_res_encrypt", i), 128'(res_encrypt), 128'(vecs[i].exp_re));
            chk($sformatf("v%0d_starts", i), 128'(n_start - s0), 128'(vecs[i].exp_starts));
            chk($sformatf("v%0d_loads", i), 128'(n_load - l0), 128'(vecs[i].exp_loads));
            chk($sformatf("v%0d_busy_end", i), 128'(busy), 128'd0);
            if (vecs[i].exp_starts == 0 && vecs[i].exp_loads == 0)
                chk($sformatf("v%0d_busy_cycles", i), 128'(n_busy - b0), 128'd0);
            if (vecs[i].exp_loads == 1) begin
                chk($sformatf("v%0d_aes_key", i), aes_key, vecs[i].data);
                chk($sformatf("v%0d_load_lat", i), 128'(load_cyc - drive_cyc), 128'd3);
            end
            if (vecs[i].exp_starts == 1) begin
                chk($sformatf("v%0d_aes_din", i), aes_din, vecs[i].data);
                chk($sformatf("v%0d_aes_encrypt", i), 128'(aes_encrypt), 128'(vecs[i].enc));
                chk($sformatf("v%0d_start_lat", i), 128'(start_cyc - drive_cyc), 128'd4);
                chk($sformatf("v%0d_core_lat", i), 128'(done_cyc - start_cyc), 128'd10);
                chk($sformatf("v%0d_res_lat", i), 128'(rv_cyc - done_cyc), 128'd1);
            end
        end

        // Timeout: core never answers
        core_en = 1'b0;
        s0 = n_start;
        send(1'b0, 1'b1, P1);
        repeat (6) @(posedge clk);
        drop();
        repeat (80) @(posedge clk);
        @(negedge clk);
        chk("to_err", 128'(err), 128'd2);
        chk("to_lat", 128'(errt_cyc - start_cyc), 128'd64);
        chk("to_res_valid", 128'(res_valid), 128'd0);
        chk("to_busy", 128'(busy), 128'd0);
        chk("to_starts", 128'(n_start - s0), 128'd1);
        core_en = 1'b1;

        // Overrun: second command while waiting for the core
        core_lat  = 20;
        core_resp = C2;
        s0 = n_start;
        send(1'b0, 1'b1, P2);
        repeat (6) @(posedge clk);
        drop();
        repeat (4) @(posedge clk);
        send(1'b0, 1'b0, K2);
        repeat (40) @(posedge clk);
        drop();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("ovr_err", 128'(err), 128'd3);
        chk("ovr_res_valid", 128'(res_valid), 128'd1);
        chk("ovr_res_data", res_data, C2);
        chk("ovr_res_encrypt", 128'(res_encrypt), 128'd1);
        chk("ovr_starts", 128'(n_start - s0), 128'd1);
        core_lat = 10;

        // Held cmd_valid: one op only, then a toggle starts a decrypt
        core_resp = C1;
        s0 = n_start;
        send(1'b0, 1'b1, P1);
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("hold_starts", 128'(n_start - s0), 128'd1);
        chk("hold_res_data", res_data, C1);
        chk("hold_err", 128'(err), 128'd0);
        drop();
        repeat (4) @(posedge clk);
        core_resp = P1;
        send(1'b0, 1'b0, C1);
        repeat (30) @(posedge clk);
        drop();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("hold2_starts", 128'(n_start - s0), 128'd2);
        chk("hold2_res_data", res_data, P1);
        chk("hold2_res_encrypt", 128'(res_encrypt), 128'd0);
        chk("hold2_res_valid", 128'(res_valid), 128'd1);

        // Reset in WAIT, core answers afterwards
        core_resp = C2;
        s0 = n_start;
        send(1'b0, 1'b1, P2);
        repeat (6) @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("rw_busy_before", 128'(busy), 128'd1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rw_busy", 128'(busy), 128'd0);
        chk("rw_key_loaded", 128'(key_loaded), 128'd0);
        chk("rw_res_valid", 128'(res_valid), 128'd0);
        chk("rw_res_data", res_data, '0);
        chk("rw_err", 128'(err), 128'd0);
        chk("rw_aes_key", aes_key, '0);
        chk("rw_aes_din", aes_din, '0);
        chk("rw_aes_encrypt", 128'(aes_encrypt), 128'd0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("rw_late_res_valid", 128'(res_valid), 128'd0);
        chk("rw_late_res_data", res_data, '0);
        chk("rw_late_busy", 128'(busy), 128'd0);
        chk("rw_late_key_loaded", 128'(key_loaded), 128'd0);
        chk("rw_starts", 128'(n_start - s0), 128'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_cmd_sequencer.md
Name: aes_cmd_sequencer

Overview:
- Sits between the SPI slave front end and the AES core, in the core clock domain.
- Accepts the 131-bit command (valid, 128-bit payload, encrypt, is_key) assembled by the SPI front end and synchronises its valid level.
- Sequences key loads and encrypt/decrypt operations on the AES core, with a watchdog.
- Holds the result, plus status, for SPI readback until the next command.

Parameters:
- DATA_W, 128, AES block and key width.
- SYNC_STAGES, 2, flops in the cmd_valid synchroniser (minimum 2).
- TIMEOUT, 64, core cycles allowed between aes_start and aes_done before abort.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  level from SPI front end, asynchronous to clk; payload stable while high.
- cmd_data  in  DATA_W  key or plaintext/ciphertext.
- cmd_encrypt  in  1  1=encrypt, 0=decrypt.
- cmd_is_key  in  1  1=payload is key.
- aes_key_load  out  1  one-cycle pulse, core captures aes_key.
- aes_key  out  DATA_W  registered key.
- aes_start  out  1  one-cycle pulse, core starts on aes_din.
- aes_din  out  DATA_W  registered block.
- aes_encrypt  out  1  mode for the current op.
- aes_done  in  1  one-cycle pulse from core.
- aes_dout  in  DATA_W  core result, valid with aes_done.
- res_valid  out  1  result held for SPI readback.
- res_data  out  DATA_W  held result.
- res_encrypt  out  1  mode of held result.
- busy  out  1  high in any state except IDLE.
- key_loaded  out  1  a key has been loaded since reset.
- err  out  2  sticky error code: 0 none, 1 no key, 2 timeout, 3 overrun.

Behaviour:
- Reset (reset_n low at a clk edge): all outputs 0; state IDLE; synchroniser and edge register cleared; key and din registers cleared.
- cmd_valid passes through a SYNC_STAGES flop chain.
- The rising edge of the synchronised level yields cmd_evt, one cycle. cmd_data, cmd_encrypt and cmd_is_key are sampled in the cmd_evt cycle.
- States: IDLE, KEYLD, START, WAIT, RESULT.
- IDLE + cmd_evt:
  - err cleared.
  - If is_key: aes_key <= cmd_data, go to KEYLD.
  - Else if key_loaded: aes_din <= cmd_data, aes_encrypt <= cmd_encrypt, res_valid <= 0, go to START.
  - Else: err <= 1, stay IDLE.
- KEYLD: aes_key_load=1 for exactly one cycle; key_loaded <= 1; next state IDLE. res_* unchanged.
- START: aes_start=1 for exactly one cycle; timeout counter <= 0; next state WAIT.
- WAIT:
  - Counter increments each cycle.
  - On aes_done: res_data <= aes_dout, res_encrypt <= aes_encrypt, res_valid <= 1, go to RESULT.
  - If the counter reaches TIMEOUT-1 without aes_done: err <= 2, res_valid stays 0, go to IDLE.
  - aes_done in the same cycle as the terminal count: done wins.
- RESULT: one cycle, then IDLE. res_valid stays high until the next accepted data command.
- cmd_evt in KEYLD/START/WAIT/RESULT: command dropped, err <= 3. The current operation is unaffected.
- aes_done outside WAIT: ignored.
- Latency:
  - Data command: cmd_evt to aes_start is 2 cycles; aes_done to res_valid is 1 cycle.
  - Key command: cmd_evt to aes_key_load is 1 cycle.
- Reset mid-operation (reset_n low in any state): immediate return to reset values next edge; key_loaded cleared; a later aes_done is ignored.
- cmd_valid held high: only one cmd_evt; it must fall and rise again for the next command.
- Counter width: $clog2(TIMEOUT)+1 bits; no wrap while in WAIT.

Decomposition:
- Shared package aes_pkg holds:
  - State enum (IDLE, KEYLD, START, WAIT, RESULT).
  - Error code constants ERR_NONE, ERR_NOKEY, ERR_TIMEOUT, ERR_OVERRUN.
  - AES_W=128.
- One sub-module, sync_edge_det: SYNC_STAGES synchroniser plus rising-edge pulse. It is reusable for the LDO chip-select path.

Test Plan:
- Key load then encrypt:
  - Stimulus: cmd is_key=1, data=000102..0F; then is_key=0, encrypt=1, data=00112233..FF; core model returns 69C4E0D8..C55A after 10 cycles.
  - Required: one aes_key_load pulse; aes_start 2 cycles after the edge; res_valid=1 with res_data=69C4..C55A; err=0.
- Data without key:
  - Stimulus: after reset, data command.
  - Required: no aes_start; err=1; busy stays 0; key_loaded=0.
- Timeout:
  - Stimulus: TIMEOUT=64, core never asserts done.
  - Required: err=2 exactly 64 cycles after aes_start; state back in IDLE; res_valid=0.
- Overrun:
  - Stimulus: second cmd_evt during WAIT.
  - Required: err=3; the first result still delivered correctly; exactly one aes_start.
- Reset mid-WAIT:
  - Stimulus: reset_n low for 1 cycle in WAIT, then a late aes_done.
  - Required: all outputs 0; late done ignored; key_loaded=0.
- Held cmd_valid:
  - Stimulus: cmd_valid high for 200 cycles.
  - Required: exactly one operation; a toggle low/high starts a second operation with decrypt.
